// File: rtl/throw_physics_if.sv
// Throw handshake between the turn controller and the projectile engine.
// The controller drives the command side; the engine returns the completion
// and hit pulses.
interface throw_physics_if;
    logic       throw_command;
    logic [7:0] power;
    logic       cat_turn;
    logic       dog_turn;
    logic       cat_throw_complete;
    logic       dog_throw_complete;
    logic       hit_cat;
    logic       hit_dog;

    modport master (
        output throw_command, power, cat_turn, dog_turn,
        input  cat_throw_complete, dog_throw_complete, hit_cat, hit_dog
    );

    modport slave (
        input  throw_command, power, cat_turn, dog_turn,
        output cat_throw_complete, dog_throw_complete, hit_cat, hit_dog
    );
endinterface

// File: rtl/throw_physics.sv
// Projectile engine: accepts a throw from the side holding the turn, steps a
// gravity trajectory once every TICK_DIV cycles, and reports the end of the
// throw (hit, out of bounds or landing) as one-cycle pulses.
module throw_physics #(
    parameter int SCREEN_W = 1024,
    parameter int GROUND_Y = 700,
    parameter int LAUNCH_Y = 699,
    parameter int CAT_X    = 100,
    parameter int DOG_X    = 900,
    parameter int HIT_R    = 16,
    parameter int TARGET_H = 48,
    parameter int GRAVITY  = 1,
    parameter int TICK_DIV = 650000
) (
    input  logic              clk,
    input  logic              rst,
    throw_physics_if.slave    bus,
    output logic              proj_active,
    output logic [10:0]       proj_x,
    output logic [10:0]       proj_y
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    // Geometry constants in the 13-bit signed datapath domain
    localparam logic signed [12:0] X_MAX    = 13'(SCREEN_W - 1);
    localparam logic signed [12:0] GROUND_S = 13'(GROUND_Y);
    localparam logic signed [12:0] LAUNCH_S = 13'(LAUNCH_Y);
    localparam logic signed [12:0] CAT_XS   = 13'(CAT_X);
    localparam logic signed [12:0] DOG_XS   = 13'(DOG_X);
    localparam logic signed [12:0] HIT_HI   = 13'(HIT_R);
    localparam logic signed [12:0] HIT_LO   = 13'(-HIT_R);
    localparam logic signed [12:0] HIT_TOP  = 13'(GROUND_Y - TARGET_H);
    localparam logic signed [12:0] GRAV_S   = 13'(GRAVITY);

    typedef enum logic [1:0] {IDLE, LAUNCH, FLIGHT, DONE} state_t;

    state_t state, state_n;

    logic signed [12:0] x, y, vx, vy;
    logic [CNT_W-1:0]   cnt;
    logic               side_dog;
    logic [7:0]         pwr;
    logic               hit_flag;

    logic               accept;
    logic               tick;
    logic signed [12:0] nx, ny, nvy, dx, tgt_x;
    logic signed [12:0] vx_mag, vy_mag;
    logic               step_hit, step_oob, step_land;
    logic               cat_done, dog_done, cat_hit, dog_hit;

    // A throw is only taken when exactly one side claims the turn
    assign accept = bus.throw_command & (bus.cat_turn ^ bus.dog_turn);
    assign tick   = (cnt == CNT_LAST);

    // Candidate next position and velocity, all from the current values
    assign nx     = x + vx;
    assign ny     = y + vy;
    assign nvy    = vy + GRAV_S;
    assign tgt_x  = side_dog ? CAT_XS : DOG_XS;
    assign dx     = nx - tgt_x;
    assign vx_mag = $signed({9'd0, pwr[7:4]});
    assign vy_mag = $signed({8'd0, pwr[7:3]});

    assign step_hit  = (dx >= HIT_LO) && (dx <= HIT_HI) && (ny >= HIT_TOP);
    assign step_oob  = nx[12] || (nx > X_MAX);
    assign step_land = (ny >= GROUND_S);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state and completion/hit pulse decode
    always_comb begin
        state_n     = state;
        cat_done    = 1'b0;
        dog_done    = 1'b0;
        cat_hit     = 1'b0;
        dog_hit     = 1'b0;
        proj_active = 1'b0;
        case (state)
            IDLE:   if (accept) state_n = LAUNCH;
            LAUNCH: begin
                proj_active = 1'b1;
                state_n     = FLIGHT;
            end
            FLIGHT: begin
                proj_active = 1'b1;
                if (tick && (step_hit || step_oob || step_land)) state_n = DONE;
            end
            DONE: begin
                state_n  = IDLE;
                cat_done = ~side_dog;
                dog_done = side_dog;
                dog_hit  = ~side_dog & hit_flag;
                cat_hit  = side_dog & hit_flag;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.cat_throw_complete = cat_done;
    assign bus.dog_throw_complete = dog_done;
    assign bus.hit_cat            = cat_hit;
    assign bus.hit_dog            = dog_hit;

    // Trajectory datapath: latch the throw, load launch values, step physics
    always_ff @(posedge clk) begin
        if (rst) begin
            x        <= '0;
            y        <= '0;
            vx       <= '0;
            vy       <= '0;
            cnt      <= '0;
            side_dog <= 1'b0;
            pwr      <= '0;
            hit_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        side_dog <= bus.dog_turn;
                        pwr      <= bus.power;
                        hit_flag <= 1'b0;
                    end
                end
                LAUNCH: begin
                    x   <= side_dog ? DOG_XS : CAT_XS;
                    y   <= LAUNCH_S;
                    vx  <= side_dog ? -vx_mag : vx_mag;
                    vy  <= -vy_mag;
                    cnt <= '0;
                end
                FLIGHT: begin
                    if (tick) begin
                        cnt <= '0;
                        vy  <= nvy;
                        if (step_hit) begin
                            x        <= nx;
                            y        <= ny;
                            hit_flag <= 1'b1;
                        end else if (step_oob) begin
                            x <= nx[12] ? 13'sd0 : X_MAX;
                            y <= ny;
                        end else if (step_land) begin
                            x <= nx;
                            y <= GROUND_S;
                        end else begin
                            x <= nx;
                            y <= ny;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign proj_x = x[10:0];
    assign proj_y = y[10:0];

endmodule

// File: tb/tb_throw_physics.sv
// Scoreboard bench for throw_physics: the driver issues throws and queues
// the expected completion; a monitor pops and compares on every pulse.
module tb_throw_physics;

    localparam int SCREEN_W = 256;
    localparam int GROUND_Y = 100;
    localparam int LAUNCH_Y = 99;
    localparam int CAT_X    = 10;
    localparam int DOG_X    = 200;
    localparam int HIT_R    = 8;
    localparam int TARGET_H = 20;
    localparam int GRAVITY  = 1;
    localparam int TICK_DIV = 4;

    typedef struct {
        int cyc;
        bit dog;
        bit hit;
        int x;
        int y;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        proj_active;
    logic [10:0] proj_x, proj_y;

    throw_physics_if bus();

    throw_physics #(
        .SCREEN_W(SCREEN_W), .GROUND_Y(GROUND_Y), .LAUNCH_Y(LAUNCH_Y),
        .CAT_X(CAT_X), .DOG_X(DOG_X), .HIT_R(HIT_R), .TARGET_H(TARGET_H),
        .GRAVITY(GRAVITY), .TICK_DIV(TICK_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .proj_active(proj_active),
        .proj_x(proj_x),
        .proj_y(proj_y)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t mon_e;
    int   last_x = 0;
    int   last_y = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference trajectory: plain integer simulation of the throw rules
    function automatic exp_t model(input bit dog, input logic [7:0] p, input int c0);
        exp_t e;
        int x, y, vx, vy, nx, ny, tx, d, n;
        bit fin;
        x  = dog ? DOG_X : CAT_X;
        y  = LAUNCH_Y;
        vx = dog ? -int'(p[7:4]) : int'(p[7:4]);
        vy = -int'(p[7:3]);
        tx = dog ? CAT_X : DOG_X;
        n = 0; fin = 0;
        e.dog = dog; e.hit = 0; e.x = 0; e.y = 0;
        while (!fin && n < 1000) begin
            n++;
            nx = x + vx;
            ny = y + vy;
            vy = vy + GRAVITY;
            d  = nx - tx;
            if (d < 0) d = -d;
            if (d <= HIT_R && ny >= GROUND_Y - TARGET_H) begin
                e.hit = 1; e.x = nx; e.y = ny; fin = 1;
            end else if (nx < 0 || nx > SCREEN_W - 1) begin
                e.x = (nx < 0) ? 0 : SCREEN_W - 1; e.y = ny; fin = 1;
            end else if (ny >= GROUND_Y) begin
                e.x = nx; e.y = GROUND_Y; fin = 1;
            end else begin
                x = nx; y = ny;
            end
        end
        e.cyc = c0 + 2 + n * TICK_DIV;
        e.x = e.x & 2047;
        e.y = e.y & 2047;
        return e;
    endfunction

    task automatic issue(input bit cat, input bit dog, input logic [7:0] p, output int c0);
        @(negedge clk);
        bus.throw_command = 1'b1;
        bus.power         = p;
        bus.cat_turn      = cat;
        bus.dog_turn      = dog;
        c0 = cyc;
        @(negedge clk);
        bus.throw_command = 1'b0;
        bus.cat_turn      = 1'b0;
        bus.dog_turn      = 1'b0;
    endtask

    task automatic push(input exp_t e);
        sb.push_back(e);
        last_x = e.x;
        last_y = e.y;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL completion_timeout: got no pulse, required %0d pending", sb.size());
            sb.delete();
        end
        @(negedge clk);
        check("idle_active", proj_active, 0);
        check("idle_hold_x", proj_x, last_x);
        check("idle_hold_y", proj_y, last_y);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every completion or hit pulse must match the head of the queue
    always @(negedge clk) begin
        if (bus.cat_throw_complete || bus.dog_throw_complete || bus.hit_cat || bus.hit_dog) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_pulse: got cat=%0d dog=%0d hc=%0d hd=%0d, required none (cycle %0d)",
                         bus.cat_throw_complete, bus.dog_throw_complete, bus.hit_cat, bus.hit_dog, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("done_cycle",   cyc, mon_e.cyc);
                check("cat_complete", int'(bus.cat_throw_complete), int'(!mon_e.dog));
                check("dog_complete", int'(bus.dog_throw_complete), int'(mon_e.dog));
                check("hit_dog",      int'(bus.hit_dog), int'(!mon_e.dog && mon_e.hit));
                check("hit_cat",      int'(bus.hit_cat), int'(mon_e.dog && mon_e.hit));
                check("final_x",      proj_x, mon_e.x);
                check("final_y",      proj_y, mon_e.y);
            end
        end
    end

    // Stimulus
    initial begin
        int   c0, c1;
        exp_t e;
        bit   dog;
        logic [7:0] p;

        bus.throw_command = 1'b0;
        bus.power         = '0;
        bus.cat_turn      = 1'b0;
        bus.dog_turn      = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_active", proj_active, 0);
        check("rst_x", proj_x, 0);
        check("rst_y", proj_y, 0);
        check("rst_cat_done", bus.cat_throw_complete, 0);
        check("rst_dog_done", bus.dog_throw_complete, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_active", proj_active, 0);

        // Cat, zero power: lands on step 2
        issue(1, 0, 8'h00, c0);
        e = '{cyc: c0 + 10, dog: 0, hit: 0, x: 10, y: 100};
        push(e);
        check("launch_active", proj_active, 1);
        wait_idle();

        // Cat hit, with a stray dog command mid-flight that must be ignored
        issue(1, 0, 8'h70, c0);
        e = '{cyc: c0 + 114, dog: 0, hit: 1, x: 206, y: 85};
        push(e);
        wait_until(c0 + 30);
        bus.throw_command = 1'b1; bus.dog_turn = 1'b1; bus.power = 8'hFF;
        @(negedge clk);
        bus.throw_command = 1'b0; bus.dog_turn = 1'b0;
        check("flight_active", proj_active, 1);
        wait_idle();

        // Dog out of bounds on the left edge
        issue(0, 1, 8'h80, c0);
        e = '{cyc: c0 + 106, dog: 1, hit: 0, x: 0, y: 8};
        push(e);
        wait_idle();

        // Ambiguous and empty turn ownership are ignored
        issue(1, 1, 8'h70, c0);
        check("both_turns_idle", proj_active, 0);
        @(negedge clk);
        check("both_turns_idle2", proj_active, 0);
        issue(0, 0, 8'h70, c0);
        check("no_turn_idle", proj_active, 0);
        repeat (3) @(negedge clk);
        check("no_turn_idle2", proj_active, 0);

        // Reset in the middle of a cat throw
        issue(1, 0, 8'h70, c0);
        wait_until(c0 + 20);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_active", proj_active, 0);
        check("midrst_x", proj_x, 0);
        check("midrst_y", proj_y, 0);
        check("midrst_cat_done", bus.cat_throw_complete, 0);
        check("midrst_hit_dog", bus.hit_dog, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("after_rst_active", proj_active, 0);
        last_x = 0; last_y = 0;
        issue(1, 0, 8'h70, c0);
        push(model(0, 8'h70, c0));
        wait_idle();

        // Randomised throws, some with a stray command during flight
        for (int i = 0; i < 12; i++) begin
            dog = 1'($urandom_range(0, 1));
            p   = 8'($urandom_range(0, 255));
            issue(!dog, dog, p, c0);
            push(model(dog, p, c0));
            if ($urandom_range(0, 1) == 1) begin
                c1 = c0 + int'($urandom_range(3, 8));
                wait_until(c1);
                bus.throw_command = 1'b1;
                bus.cat_turn = 1'($urandom_range(0, 1));
                bus.dog_turn = !bus.cat_turn;
                bus.power = 8'($urandom_range(0, 255));
                @(negedge clk);
                bus.throw_command = 1'b0; bus.cat_turn = 1'b0; bus.dog_turn = 1'b0;
            end
            wait_idle();
        end

        repeat (4) @(negedge clk);
        check("queue_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/throw_physics.md
# throw_physics

Projectile engine on the far end of the turn controller's throw handshake. It accepts a one-cycle throw command with an 8-bit power value from the side whose turn it is. It then steps a gravity-driven trajectory at a fixed physics tick, detects a hit on the opposing character or a landing or out-of-bounds event, and returns a one-cycle completion pulse on the thrower's complete line. Its position outputs feed the projectile sprite renderer.

## Interface
Parameters:
- SCREEN_W, 1024: playfield width in pixels; valid x is 0..SCREEN_W-1.
- GROUND_Y, 700: ground line; y >= GROUND_Y means landed.
- LAUNCH_Y, 699: launch y for both sides; must be less than GROUND_Y.
- CAT_X, 100: cat launch x, and the dog's target centre when the dog throws.
- DOG_X, 900: dog launch x, and the cat's target centre when the cat throws.
- HIT_R, 16: half-width of the target hit box in x.
- TARGET_H, 48: target hit-box height above GROUND_Y.
- GRAVITY, 1: added to vy every step; must be at least 1.
- TICK_DIV, 650000: clock cycles per physics step; must be at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- throw_command  in  1  one-cycle throw request.
- power  in  8  throw power, sampled with throw_command.
- cat_turn  in  1  cat owns the turn.
- dog_turn  in  1  dog owns the turn.
- cat_throw_complete  out  1  one-cycle pulse when the cat's throw ends.
- dog_throw_complete  out  1  one-cycle pulse when the dog's throw ends.
- hit_cat  out  1  one-cycle pulse, coincident with dog_throw_complete, when the dog's projectile hit.
- hit_dog  out  1  one-cycle pulse, coincident with cat_throw_complete, when the cat's projectile hit.
- proj_active  out  1  high in LAUNCH and FLIGHT.
- proj_x  out  11  projectile x, unsigned.
- proj_y  out  11  projectile y, unsigned.

## Operation
- States are IDLE, LAUNCH, FLIGHT and DONE.
- IDLE:
  - A command is accepted only when throw_command=1 and exactly one of cat_turn or dog_turn is 1.
  - On acceptance, latch the side and power, then go to LAUNCH.
  - Any other combination is ignored.
- LAUNCH, one cycle:
  - Load x to CAT_X for the cat or DOG_X for the dog, and y to LAUNCH_Y.
  - Load vx to +power[7:4] for the cat or -power[7:4] for the dog.
  - Load vy to -power[7:3].
  - Clear the tick counter, then go to FLIGHT.
- FLIGHT:
  - The tick counter increments each cycle.
  - When it equals TICK_DIV-1, perform a step and reset the counter to 0.
- Step, with all right-hand sides taken from old values:
  - x' = x + vx
  - y' = y + vy
  - vy' = vy + GRAVITY
- Step checks, evaluated on x' and y' in priority order:
  1. Hit: |x' - target_x| <= HIT_R and y' >= GROUND_Y - TARGET_H. Store x' and y', flag a hit, go to DONE.
  2. Out of bounds: x' < 0 or x' > SCREEN_W-1. Clamp x to 0 or SCREEN_W-1, store y', go to DONE with no hit.
  3. Landed: y' >= GROUND_Y. Store x', set y = GROUND_Y, go to DONE with no hit.
  4. Otherwise store all new values and stay in FLIGHT.
- DONE, one cycle:
  - Pulse the thrower's *_throw_complete.
  - Pulse hit_dog (cat thrower) or hit_cat (dog thrower) when flagged.
  - Go to IDLE.
- Arithmetic:
  - x, y, vx and vy are 13-bit signed internally.
  - proj_x and proj_y are the low 11 bits of x and y, always in range after clamping.
- throw_command in LAUNCH, FLIGHT or DONE is ignored, with no queuing.
- Changes on the turn inputs after acceptance are ignored; the latched side governs the whole throw.
- In IDLE, proj_x and proj_y hold the final position of the last throw.

## Timing
- Reset values: state IDLE; every output 0; internal x, y, vx, vy and counter all 0.
- Let command be sampled at cycle 0:
  - LAUNCH occurs at cycle 1.
  - FLIGHT starts at cycle 2.
  - Step k registers at the end of cycle 1 + k*TICK_DIV.
- If the terminating step is step n, DONE and the completion pulse occur at cycle 2 + n*TICK_DIV.
- Completion and hit pulses are exactly one cycle wide.
- The earliest next accepted command is the cycle after DONE.
- rst asserted mid-throw returns the block to IDLE at the next edge, with every output at its reset value and no completion pulse.

## Test plan
Bench parameters for all scenarios: SCREEN_W=256, GROUND_Y=100, LAUNCH_Y=99, CAT_X=10, DOG_X=200, HIT_R=8, TARGET_H=20, GRAVITY=1, TICK_DIV=4.
- **Cat, zero power.** cat_turn=1, power=0x00. Required: step 2 lands; cat_throw_complete=1 at cycle 10 only; proj_x=10, proj_y=100; hit_dog=0.
- **Cat hit.** cat_turn=1, power=0x70 (vx=+7, vy=-14). Required: hit at step 28 with x=206, y=85; cat_throw_complete=1 and hit_dog=1 at cycle 114.
- **Dog out of bounds.** dog_turn=1, power=0x80 (vx=-8, vy=-16). Required: x' goes negative at step 26; proj_x=0; dog_throw_complete=1 at cycle 106; hit_cat=0.
- **Ignored commands.** Pulse throw_command with both turns high, then with both low. Required: state stays IDLE. A second throw_command during FLIGHT must not change the trajectory or the pulse timing.
- **Reset mid-flight.** Assert rst at cycle 20 of a 0x70 cat throw. Required: all outputs 0 next cycle; no complete pulse; the next command launches normally.
